// File: rtl/fetch_queue_if.sv
// Ready/valid handshake carrying one fetched instruction {pc, instr, predict_taken}.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic            pred_taken;

  modport master (output valid, pc, instr, pred_taken, input ready);
  modport slave  (input valid, pc, instr, pred_taken, output ready);
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular instruction buffer between fetch and decode.
// It decouples fetch from decode, lets decode stall, and supports a one-cycle flush
// on redirects. When no entry is valid, decode sees a NOP.
// Optional macro FETCH_QUEUE_BYPASS_EN: when the queue is empty, an offered entry is
// passed straight to decode in the same cycle, and it is stored only if decode stalls.
module fetch_queue #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,   // power of two, >= 2
  parameter logic [XLEN-1:0] NOP_INSTR = 'h00000013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  fetch_queue_if.slave               enq,
  fetch_queue_if.master              deq,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            pred_taken;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;   // the MSB is the wrap bit
  logic [CW-1:0] count_q;
  logic          empty, full;
  logic          enq_fire, deq_fire, bypass;
  logic          wr_en, rd_adv;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // enq.ready depends only on registered state and flush, never on deq.ready.
  assign enq.ready = !full && !flush;
  assign enq_fire  = enq.valid && enq.ready;
  assign deq_fire  = deq.valid && deq.ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && enq.valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry that decode consumes right away is never stored.
  assign wr_en  = enq_fire && !(bypass && deq.ready);
  assign rd_adv = deq_fire && !bypass;
  assign count  = count_q;

  // Head presentation: the stored head, the bypassed entry, or the empty NOP.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch can be inferred.
    deq.valid      = 1'b0;
    deq.pc         = '0;
    deq.instr      = NOP_INSTR;
    deq.pred_taken = 1'b0;
    if (!flush) begin
      if (!empty) begin
        deq.valid      = 1'b1;
        deq.pc         = mem[rd_ptr[AW-1:0]].pc;
        deq.instr      = mem[rd_ptr[AW-1:0]].instr;
        deq.pred_taken = mem[rd_ptr[AW-1:0]].pred_taken;
      end else if (bypass) begin
        deq.valid      = 1'b1;
        deq.pc         = enq.pc;
        deq.instr      = enq.instr;
        deq.pred_taken = enq.pred_taken;
      end
    end
  end

  // Pointer and occupancy update; reset takes priority over flush, and flush over traffic.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_adv})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset, because the pointers alone determine which entries are valid.
    if (!reset && !flush && wr_en) begin
      mem[wr_ptr[AW-1:0]] <= '{pc: enq.pc, instr: enq.instr, pred_taken: enq.pred_taken};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue. A behavioural occupancy model predicts the
// handshakes, and a scoreboard of expected entries checks everything presented to decode.
module tb_fetch_queue;

  localparam int              XLEN  = 32;
  localparam int              DEPTH = 4;
  localparam int              CW    = $clog2(DEPTH+1);
  localparam logic [XLEN-1:0] NOP   = 32'h00000013;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            pred;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [CW-1:0] count;

  fetch_queue_if #(.XLEN(XLEN)) enq_if ();
  fetch_queue_if #(.XLEN(XLEN)) deq_if ();

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .enq   (enq_if),
    .deq   (deq_if),
    .count (count)
  );

  always #5 clk = ~clk;

  entry_t sb[$];
  int     model_count   = 0;
  bit     last_enq_fire = 1'b0;
  int     vectors       = 0;
  int     miscompares   = 0;

  function automatic logic [XLEN-1:0] instr_of(input logic [XLEN-1:0] pc);
    return 32'hA5000000 ^ (pc << 4) ^ 32'h00000093;
  endfunction

  task automatic offer(input bit v, input logic [XLEN-1:0] pc, input logic pred);
    enq_if.valid      = v;
    enq_if.pc         = pc;
    enq_if.instr      = instr_of(pc);
    enq_if.pred_taken = pred;
  endtask

  // One clock cycle: compare at the falling edge against the model, then advance past the rising edge.
  task automatic tick();
    entry_t e;
    bit     byp, exp_er, exp_dv, ef, df;
    @(negedge clk);
    last_enq_fire = 1'b0;
    if (reset) begin
      sb.delete();
      model_count = 0;
    end else begin
      byp    = BYPASS && (model_count == 0) && enq_if.valid && !flush;
      exp_er = (model_count < DEPTH) && !flush;
      exp_dv = ((model_count != 0) || byp) && !flush;
      vectors++;
      if (enq_if.ready !== exp_er) begin
        miscompares++;
        $display("FAIL enq_ready: got %b expected %b (t=%0t)", enq_if.ready, exp_er, $time);
      end
      vectors++;
      if (deq_if.valid !== exp_dv) begin
        miscompares++;
        $display("FAIL deq_valid: got %b expected %b (t=%0t)", deq_if.valid, exp_dv, $time);
      end
      vectors++;
      if (count !== model_count[CW-1:0]) begin
        miscompares++;
        $display("FAIL count: got %0d expected %0d (t=%0t)", count, model_count, $time);
      end
      ef = enq_if.valid && exp_er;
      df = exp_dv && deq_if.ready;
      if (ef) sb.push_back('{pc: enq_if.pc, instr: enq_if.instr, pred: enq_if.pred_taken});
      vectors++;
      if (exp_dv) begin
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL head: scoreboard empty while deq_valid expected (t=%0t)", $time);
        end else begin
          e = sb[0];
          if (deq_if.pc !== e.pc || deq_if.instr !== e.instr || deq_if.pred_taken !== e.pred) begin
            miscompares++;
            $display("FAIL head: got pc=%h instr=%h pred=%b expected pc=%h instr=%h pred=%b (t=%0t)",
                     deq_if.pc, deq_if.instr, deq_if.pred_taken, e.pc, e.instr, e.pred, $time);
          end
        end
      end else if (deq_if.pc !== '0 || deq_if.instr !== NOP || deq_if.pred_taken !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_head: got pc=%h instr=%h pred=%b expected pc=0 instr=%h pred=0 (t=%0t)",
                 deq_if.pc, deq_if.instr, deq_if.pred_taken, NOP, $time);
      end
      if (df && sb.size() > 0) void'(sb.pop_front());
      if (flush) begin
        sb.delete();
        model_count = 0;
      end else begin
        model_count = model_count + int'(ef) - int'(df);
      end
      last_enq_fire = ef;
    end
    @(posedge clk);
    #1;
  endtask

  // Drain with decode ready; exceeding the cycle budget counts as a miscompare.
  task automatic drain();
    offer(1'b0, '0, 1'b0);
    deq_if.ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && model_count > 0; i++) tick();
    vectors++;
    if (model_count != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", model_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #2;
    vectors++;
    if (enq_if.ready !== 1'b1 || deq_if.valid !== 1'b0 || deq_if.instr !== NOP || count !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got er=%b dv=%b instr=%h count=%0d expected er=1 dv=0 instr=%h count=0",
               enq_if.ready, deq_if.valid, deq_if.instr, count, NOP);
    end
    tick();
    tick();
  endtask

  task automatic test_fill();
    deq_if.ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      offer(1'b1, 32'(4 * k), 1'b0);
      tick();
    end
    offer(1'b1, 32'h10, 1'b0);
    #2;
    vectors++;
    if (count !== CW'(DEPTH) || enq_if.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full: got count=%0d er=%b expected count=%0d er=0", count, enq_if.ready, DEPTH);
    end
    for (int k = 0; k < 3; k++) begin
      #2;
      vectors++;
      if (enq_if.ready !== 1'b0) begin
        miscompares++;
        $display("FAIL full_hold: got er=%b expected 0 (hold %0d)", enq_if.ready, k);
      end
      tick();
    end
    // Dequeue while full: the offer is refused in that same cycle.
    deq_if.ready = 1'b1;
    #2;
    vectors++;
    if (enq_if.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_deq_refuse: got er=%b expected 0", enq_if.ready);
    end
    tick();
    #2;
    vectors++;
    if (enq_if.ready !== 1'b1 || count !== CW'(DEPTH - 1)) begin
      miscompares++;
      $display("FAIL accept_after_drop: got er=%b count=%0d expected er=1 count=%0d",
               enq_if.ready, count, DEPTH - 1);
    end
    tick();
    drain();
  endtask

  task automatic test_stream();
    logic [XLEN-1:0] pc = '0;
    int              steady = BYPASS ? 0 : 1;
    deq_if.ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      offer(1'b1, pc, pc[2]);
      #2;
      vectors++;
      if (count !== CW'((k == 0) ? 0 : steady)) begin
        miscompares++;
        $display("FAIL stream_count: got %0d expected %0d (cycle %0d)", count, (k == 0) ? 0 : steady, k);
      end
      tick();
      if (last_enq_fire) pc = pc + 32'd4;
    end
    drain();
  endtask

  task automatic test_flush();
    deq_if.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      offer(1'b1, 32'h30 + 32'(4 * k), 1'b1);
      tick();
    end
    flush = 1'b1;
    deq_if.ready = 1'b1;
    offer(1'b1, 32'h3C, 1'b0);
    #2;
    vectors++;
    if (enq_if.ready !== 1'b0 || deq_if.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_cycle: got er=%b dv=%b expected er=0 dv=0", enq_if.ready, deq_if.valid);
    end
    tick();
    flush = 1'b0;
    offer(1'b0, '0, 1'b0);
    #2;
    vectors++;
    if (count !== '0 || deq_if.instr !== NOP) begin
      miscompares++;
      $display("FAIL after_flush: got count=%0d instr=%h expected count=0 instr=%h", count, deq_if.instr, NOP);
    end
    tick();
    deq_if.ready = 1'b0;
    offer(1'b1, 32'h40, 1'b1);
    tick();
    offer(1'b0, '0, 1'b0);
    #2;
    vectors++;
    if (deq_if.valid !== 1'b1 || deq_if.pc !== 32'h40) begin
      miscompares++;
      $display("FAIL post_flush_head: got dv=%b pc=%h expected dv=1 pc=00000040", deq_if.valid, deq_if.pc);
    end
    tick();
    drain();
  endtask

  task automatic test_mid_reset();
    deq_if.ready = 1'b0;
    offer(1'b1, 32'h100, 1'b1);
    tick();
    offer(1'b1, 32'h104, 1'b0);
    tick();
    offer(1'b1, 32'h108, 1'b1);
    deq_if.ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    offer(1'b0, '0, 1'b0);
    #2;
    vectors++;
    if (count !== '0 || deq_if.valid !== 1'b0 || enq_if.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset: got count=%0d dv=%b er=%b expected count=0 dv=0 er=1",
               count, deq_if.valid, enq_if.ready);
    end
    for (int k = 0; k < 3; k++) tick();
    offer(1'b1, 32'h200, 1'b0);
    tick();
    drain();
  endtask

  task automatic test_pred();
    deq_if.ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      offer(1'b1, 32'h20 + 32'(4 * k), ~k[0]);
      tick();
    end
    drain();
`ifdef FETCH_QUEUE_BYPASS_EN
    deq_if.ready = 1'b1;
    offer(1'b1, 32'h20, 1'b1);
    #2;
    vectors++;
    if (deq_if.valid !== 1'b1 || deq_if.pc !== 32'h20 || deq_if.pred_taken !== 1'b1) begin
      miscompares++;
      $display("FAIL bypass_same_cycle: got dv=%b pc=%h pred=%b expected dv=1 pc=00000020 pred=1",
               deq_if.valid, deq_if.pc, deq_if.pred_taken);
    end
    tick();
    offer(1'b0, '0, 1'b0);
    #2;
    vectors++;
    if (count !== '0) begin
      miscompares++;
      $display("FAIL bypass_count: got %0d expected 0", count);
    end
    tick();
`endif
  endtask

  initial begin
    reset        = 1'b1;
    flush        = 1'b0;
    deq_if.ready = 1'b0;
    offer(1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_stream();
    test_flush();
    test_mid_reset();
    test_pred();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
